// File: rtl/lc3_mem_arbiter_if.sv
// lc3_mem_arbiter_if
//   Bundle of every non-clock signal around the LC3 memory arbiter.
//   Core fetch side : instrmem_rd, pc -> Instr_dout, complete_instr
//   Core data side  : data_req, Data_rd, Data_addr, Data_dout -> Data_din, complete_data
//   Memory side     : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
//   Modports: slave  = the arbiter itself
//             master = the environment (core + memory) that talks to it
interface lc3_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          instrmem_rd;
  logic [AW-1:0] pc;
  logic [DW-1:0] Instr_dout;
  logic          complete_instr;
  logic          data_req;
  logic          Data_rd;
  logic [AW-1:0] Data_addr;
  logic [DW-1:0] Data_dout;
  logic [DW-1:0] Data_din;
  logic          complete_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  instrmem_rd, pc, data_req, Data_rd, Data_addr, Data_dout, mem_rdata,
    output Instr_dout, complete_instr, Data_din, complete_data,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output instrmem_rd, pc, data_req, Data_rd, Data_addr, Data_dout, mem_rdata,
    input  Instr_dout, complete_instr, Data_din, complete_data,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter
//   Single-port memory arbiter / access sequencer for the LC3 core. One access
//   at a time: IDLE (grant) -> ISSUE (mem_en) -> WAIT (LAT cycles) -> DONE
//   (completion pulse). Occupancy is LAT+3 cycles per access.
// Parameters: LAT memory latency (1..15), AW address width, DW data width.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : lc3_mem_arbiter_if.slave (fetch port, data port, memory port)
// Optional feature macro: LC3_ARB_FAIRNESS_EN
//   defined   -> after a data grant, a contending fetch wins the next grant
//   undefined -> strict data priority (fetch may starve)
module lc3_mem_arbiter #(
  parameter int LAT = 1,
  parameter int AW  = 16,
  parameter int DW  = 16
) (
  input  logic               clock,
  input  logic               reset,
  lc3_mem_arbiter_if.slave   bus
);

  generate
    if (LAT < 1 || LAT > 15) begin : g_bad_lat
      $fatal(1, "lc3_mem_arbiter: LAT=%0d outside legal range 1..15", LAT);
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state_reg,      state_next;
  logic [3:0]    cnt_reg,        cnt_next;
  logic          own_data_reg,   own_data_next;   // 1 = current access belongs to data port
  logic          we_reg,         we_next;
  logic [AW-1:0] addr_reg,       addr_next;
  logic [DW-1:0] wdata_reg,      wdata_next;
  logic          mem_en_reg,     mem_en_next;
  logic [DW-1:0] instr_dout_reg, instr_dout_next;
  logic [DW-1:0] data_din_reg,   data_din_next;
  logic          cmp_i_reg,      cmp_i_next;
  logic          cmp_d_reg,      cmp_d_next;
  logic          grant_data;
`ifdef LC3_ARB_FAIRNESS_EN
  logic          last_was_data_reg, last_was_data_next;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      own_data_reg   <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      mem_en_reg     <= 1'b0;
      instr_dout_reg <= '0;
      data_din_reg   <= '0;
      cmp_i_reg      <= 1'b0;
      cmp_d_reg      <= 1'b0;
`ifdef LC3_ARB_FAIRNESS_EN
      last_was_data_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      own_data_reg   <= own_data_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      mem_en_reg     <= mem_en_next;
      instr_dout_reg <= instr_dout_next;
      data_din_reg   <= data_din_next;
      cmp_i_reg      <= cmp_i_next;
      cmp_d_reg      <= cmp_d_next;
`ifdef LC3_ARB_FAIRNESS_EN
      last_was_data_reg <= last_was_data_next;
`endif
    end
  end

  // Every output is a register, so the *_next values computed here appear on
  // the pins one cycle later: a grant in IDLE raises mem_en during ISSUE, and
  // the last WAIT cycle raises complete_* during DONE.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    own_data_next   = own_data_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    mem_en_next     = 1'b0;
    instr_dout_next = instr_dout_reg;
    data_din_next   = data_din_reg;
    cmp_i_next      = 1'b0;
    cmp_d_next      = 1'b0;
    grant_data      = 1'b0;
`ifdef LC3_ARB_FAIRNESS_EN
    last_was_data_next = last_was_data_reg;
`endif

    unique case (state_reg)
      IDLE: begin
        if (bus.data_req || bus.instrmem_rd) begin
          // Data wins by default: a stalled memory stage holds the whole pipe.
          grant_data = bus.data_req;
`ifdef LC3_ARB_FAIRNESS_EN
          if (bus.data_req && bus.instrmem_rd && last_was_data_reg)
            grant_data = 1'b0;
          last_was_data_next = grant_data;
`endif
          own_data_next = grant_data;
          if (grant_data) begin
            addr_next  = bus.Data_addr;
            we_next    = ~bus.Data_rd;
            wdata_next = bus.Data_dout;
          end else begin
            addr_next  = bus.pc;
            we_next    = 1'b0;
          end
          mem_en_next = 1'b1;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = 4'(LAT);
        state_next = WAIT;
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        // cnt_reg==1 is exactly LAT cycles after the mem_en cycle.
        if (cnt_reg == 4'd1) begin
          if (!we_reg) begin
            if (own_data_reg) data_din_next   = bus.mem_rdata;
            else              instr_dout_next = bus.mem_rdata;
          end
          cmp_d_next = own_data_reg;
          cmp_i_next = ~own_data_reg;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_en         = mem_en_reg;
  assign bus.mem_we         = we_reg;
  assign bus.mem_addr       = addr_reg;
  assign bus.mem_wdata      = wdata_reg;
  assign bus.Instr_dout     = instr_dout_reg;
  assign bus.Data_din       = data_din_reg;
  assign bus.complete_instr = cmp_i_reg;
  assign bus.complete_data  = cmp_d_reg;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter
//   Three arbiters (LAT = 1, 2, 15) share one clock, one reset and one
//   behavioural memory. Expected values come from a word-level model
//   (model_mem + per-port expected output registers) and from the access
//   timeline: mem_en at cycle 1, completion at cycle 2+LAT, spacing LAT+3.
module tb_lc3_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // per-instance stimulus / observation
  logic        i_instr_rd [3];
  logic [15:0] i_pc       [3];
  logic        i_data_req [3];
  logic        i_data_rd  [3];
  logic [15:0] i_data_addr[3];
  logic [15:0] i_data_dout[3];
  logic        o_mem_en   [3];
  logic        o_mem_we   [3];
  logic [15:0] o_mem_addr [3];
  logic [15:0] o_mem_wd   [3];
  logic [15:0] o_ins      [3];
  logic [15:0] o_din      [3];
  logic        o_cmp_i    [3];
  logic        o_cmp_d    [3];

  // environment memory and per-instance read-latency pipes
  logic [15:0] mem_arr [0:65535];
  logic [15:0] rd_pipe [3][16];

  // reference model
  logic [15:0] model_mem [logic [15:0]];
  logic [15:0] exp_ins [3];
  logic [15:0] exp_din [3];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 15);
  endfunction

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return a ^ 16'h5A5A;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 2 : 15);
      lc3_mem_arbiter_if #(.AW(16), .DW(16)) bif ();
      assign bif.instrmem_rd = i_instr_rd[gi];
      assign bif.pc          = i_pc[gi];
      assign bif.data_req    = i_data_req[gi];
      assign bif.Data_rd     = i_data_rd[gi];
      assign bif.Data_addr   = i_data_addr[gi];
      assign bif.Data_dout   = i_data_dout[gi];
      assign bif.mem_rdata   = rd_pipe[gi][L-1];
      assign o_mem_en[gi]    = bif.mem_en;
      assign o_mem_we[gi]    = bif.mem_we;
      assign o_mem_addr[gi]  = bif.mem_addr;
      assign o_mem_wd[gi]    = bif.mem_wdata;
      assign o_ins[gi]       = bif.Instr_dout;
      assign o_din[gi]       = bif.Data_din;
      assign o_cmp_i[gi]     = bif.complete_instr;
      assign o_cmp_d[gi]     = bif.complete_data;
      lc3_mem_arbiter #(.LAT(L), .AW(16), .DW(16)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bif)
      );
    end
  endgenerate

  // Memory: write on mem_en&mem_we; read data valid exactly LAT cycles after
  // mem_en, random garbage on every other cycle.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (o_mem_en[k] && o_mem_we[k]) mem_arr[o_mem_addr[k]] <= o_mem_wd[k];
      rd_pipe[k][0] <= (o_mem_en[k] && !o_mem_we[k]) ? mem_arr[o_mem_addr[k]] : 16'($urandom);
      for (int j = 1; j < 16; j++) rd_pipe[k][j] <= rd_pipe[k][j-1];
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // Drive one access starting in an IDLE cycle (cycle 0), observe until its
  // completion pulse, then advance to the following IDLE cycle.
  task automatic observe_access(input int k, input bit is_data, input bit rd,
      input logic [15:0] addr, input logic [15:0] wd, input int budget,
      output int en_cyc, output logic [15:0] en_addr, output logic en_we,
      output logic [15:0] en_wd, output int done_cyc, output bit done_i,
      output bit done_d, output logic [15:0] ins_out, output logic [15:0] din_out);
    en_cyc = -1; en_addr = '0; en_we = 1'b0; en_wd = '0;
    done_cyc = -1; done_i = 1'b0; done_d = 1'b0; ins_out = '0; din_out = '0;
    if (is_data) begin
      i_data_req[k] = 1'b1; i_data_rd[k] = rd; i_data_addr[k] = addr; i_data_dout[k] = wd;
    end else begin
      i_instr_rd[k] = 1'b1; i_pc[k] = addr;
    end
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (o_mem_en[k] && en_cyc < 0) begin
        en_cyc = c; en_addr = o_mem_addr[k]; en_we = o_mem_we[k]; en_wd = o_mem_wd[k];
      end
      if (c == 2) begin
        // post-grant changes must be ignored
        i_pc[k] = 16'($urandom); i_data_addr[k] = 16'($urandom); i_data_dout[k] = 16'($urandom);
        i_data_rd[k] = 1'($urandom);
      end
      if (o_cmp_i[k] || o_cmp_d[k]) begin
        done_cyc = c; done_i = o_cmp_i[k]; done_d = o_cmp_d[k];
        ins_out = o_ins[k]; din_out = o_din[k];
        break;
      end
    end
    i_instr_rd[k] = 1'b0; i_data_req[k] = 1'b0;
    $display("txn k=%0d %s addr=%h wd=%h en@%0d done@%0d instr=%h din=%h",
             k, is_data ? (rd ? "DRD" : "DWR") : "FET", addr, wd, en_cyc, done_cyc, ins_out, din_out);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (o_mem_en[k] !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en k=%0d: got %b expected 0", k, o_mem_en[k]); end
      n_checks++; if (o_mem_we[k] !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we k=%0d: got %b expected 0", k, o_mem_we[k]); end
      n_checks++; if (o_mem_addr[k] !== 16'h0) begin n_fail++; $display("FAIL rst_mem_addr k=%0d: got %h expected 0", k, o_mem_addr[k]); end
      n_checks++; if (o_mem_wd[k] !== 16'h0) begin n_fail++; $display("FAIL rst_mem_wdata k=%0d: got %h expected 0", k, o_mem_wd[k]); end
      n_checks++; if (o_ins[k] !== 16'h0) begin n_fail++; $display("FAIL rst_instr_dout k=%0d: got %h expected 0", k, o_ins[k]); end
      n_checks++; if (o_din[k] !== 16'h0) begin n_fail++; $display("FAIL rst_data_din k=%0d: got %h expected 0", k, o_din[k]); end
      n_checks++; if (o_cmp_i[k] !== 1'b0 || o_cmp_d[k] !== 1'b0) begin n_fail++; $display("FAIL rst_complete k=%0d: got %b%b expected 00", k, o_cmp_i[k], o_cmp_d[k]); end
      exp_ins[k] = '0; exp_din[k] = '0;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    int ec, dc; logic [15:0] ea, ew, io, dout; logic we; bit di, dd;
    mem_arr[16'h3000] = 16'h1021; model_mem[16'h3000] = 16'h1021;
    observe_access(1, 1'b0, 1'b1, 16'h3000, 16'h0, 20, ec, ea, we, ew, dc, di, dd, io, dout);
    n_checks++; if (ec !== 1) begin n_fail++; $display("FAIL fetch_en_cycle: got %0d expected 1", ec); end
    n_checks++; if (ea !== 16'h3000 || we !== 1'b0) begin n_fail++; $display("FAIL fetch_en_bus: got addr=%h we=%b expected 3000/0", ea, we); end
    n_checks++; if (dc !== 4 || di !== 1'b1 || dd !== 1'b0) begin n_fail++; $display("FAIL fetch_done: got cyc=%0d i=%b d=%b expected 4/1/0", dc, di, dd); end
    n_checks++; if (io !== 16'h1021) begin n_fail++; $display("FAIL fetch_data: got %h expected 1021", io); end
    exp_ins[1] = 16'h1021;
  endtask

  task automatic test_data_write();
    int ec, dc; logic [15:0] ea, ew, io, dout; logic we; bit di, dd;
    observe_access(1, 1'b1, 1'b0, 16'h4000, 16'hBEEF, 20, ec, ea, we, ew, dc, di, dd, io, dout);
    n_checks++; if (ec !== 1 || we !== 1'b1 || ew !== 16'hBEEF || ea !== 16'h4000) begin
      n_fail++; $display("FAIL write_issue: got cyc=%0d we=%b wd=%h addr=%h expected 1/1/BEEF/4000", ec, we, ew, ea); end
    n_checks++; if (dc !== 2 + lat_of(1) || dd !== 1'b1 || di !== 1'b0) begin
      n_fail++; $display("FAIL write_done: got cyc=%0d d=%b i=%b expected %0d/1/0", dc, dd, di, 2 + lat_of(1)); end
    n_checks++; if (dout !== exp_din[1]) begin n_fail++; $display("FAIL write_din_held: got %h expected %h", dout, exp_din[1]); end
    model_mem[16'h4000] = 16'hBEEF;
    observe_access(1, 1'b1, 1'b1, 16'h4000, 16'h0, 20, ec, ea, we, ew, dc, di, dd, io, dout);
    n_checks++; if (dc !== 2 + lat_of(1) || dd !== 1'b1 || we !== 1'b0) begin
      n_fail++; $display("FAIL readback_done: got cyc=%0d d=%b we=%b expected %0d/1/0", dc, dd, we, 2 + lat_of(1)); end
    n_checks++; if (dout !== model_rd(16'h4000)) begin n_fail++; $display("FAIL readback_data: got %h expected %h", dout, model_rd(16'h4000)); end
    exp_din[1] = model_rd(16'h4000);
  endtask

  task automatic test_contention();
    int d_cyc = -1, i_cyc = -1, n_en = 0;
    int en_c[2]; logic [15:0] en_a[2];
    logic [15:0] a = 16'h6000 | 16'($urandom_range(0, 255));
    logic [15:0] p = 16'h3100 | 16'($urandom_range(0, 255));
    logic [15:0] din_s = '0, ins_s = '0;
    en_c[0] = -1; en_c[1] = -1; en_a[0] = '0; en_a[1] = '0;
    i_data_req[0] = 1'b1; i_data_rd[0] = 1'b1; i_data_addr[0] = a;
    i_instr_rd[0] = 1'b1; i_pc[0] = p;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (o_mem_en[0] && n_en < 2) begin en_c[n_en] = c; en_a[n_en] = o_mem_addr[0]; n_en++; end
      if (o_cmp_d[0] && d_cyc < 0) begin d_cyc = c; din_s = o_din[0]; i_data_req[0] = 1'b0; end
      if (o_cmp_i[0]) begin i_cyc = c; ins_s = o_ins[0]; i_instr_rd[0] = 1'b0; break; end
    end
    i_instr_rd[0] = 1'b0; i_data_req[0] = 1'b0;
    $display("txn k=0 contention data@%0d fetch_en@%0d fetch@%0d", d_cyc, en_c[1], i_cyc);
    @(negedge clk);
    n_checks++; if (en_c[0] !== 1 || en_a[0] !== a) begin n_fail++; $display("FAIL cont_data_issue: got cyc=%0d addr=%h expected 1/%h", en_c[0], en_a[0], a); end
    n_checks++; if (d_cyc !== 3) begin n_fail++; $display("FAIL cont_data_done: got %0d expected 3", d_cyc); end
    n_checks++; if (din_s !== model_rd(a)) begin n_fail++; $display("FAIL cont_data_val: got %h expected %h", din_s, model_rd(a)); end
    n_checks++; if (en_c[1] !== 5 || en_a[1] !== p) begin n_fail++; $display("FAIL cont_fetch_issue: got cyc=%0d addr=%h expected 5/%h", en_c[1], en_a[1], p); end
    n_checks++; if (i_cyc !== 7) begin n_fail++; $display("FAIL cont_fetch_done: got %0d expected 7", i_cyc); end
    n_checks++; if (ins_s !== model_rd(p)) begin n_fail++; $display("FAIL cont_fetch_val: got %h expected %h", ins_s, model_rd(p)); end
    exp_din[0] = model_rd(a); exp_ins[0] = model_rd(p);
  endtask

  task automatic test_starvation();
    int nd = 0, ni = 0, prev = -1;
    logic [15:0] a = 16'h7000, p = 16'h3200;
    i_data_req[0] = 1'b1; i_data_rd[0] = 1'b1; i_data_addr[0] = a;
    i_instr_rd[0] = 1'b1; i_pc[0] = p;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (o_cmp_d[0] || o_cmp_i[0]) begin
`ifdef LC3_ARB_FAIRNESS_EN
        n_checks++; if (prev >= 0 && int'(o_cmp_d[0]) == prev) begin
          n_fail++; $display("FAIL starve_alternate c=%0d: got data=%b expected data=%b", c, o_cmp_d[0], ~prev[0]); end
`endif
        if (o_cmp_d[0]) begin
          nd++;
          n_checks++; if (o_din[0] !== model_rd(a)) begin n_fail++; $display("FAIL starve_data_val: got %h expected %h", o_din[0], model_rd(a)); end
        end else begin
          ni++;
          n_checks++; if (o_ins[0] !== model_rd(p)) begin n_fail++; $display("FAIL starve_fetch_val: got %h expected %h", o_ins[0], model_rd(p)); end
        end
        prev = int'(o_cmp_d[0]);
      end
    end
    i_data_req[0] = 1'b0; i_instr_rd[0] = 1'b0;
    $display("txn k=0 starvation window=60 data_done=%0d fetch_done=%0d", nd, ni);
    @(negedge clk);
`ifdef LC3_ARB_FAIRNESS_EN
    n_checks++; if (nd !== 8 || ni !== 7) begin n_fail++; $display("FAIL starve_counts: got d=%0d i=%0d expected 8/7", nd, ni); end
    exp_ins[0] = model_rd(p);
`else
    n_checks++; if (nd !== 15 || ni !== 0) begin n_fail++; $display("FAIL starve_counts: got d=%0d i=%0d expected 15/0", nd, ni); end
`endif
    exp_din[0] = model_rd(a);
  endtask

  task automatic test_back_to_back(input int k);
    logic [15:0] pcq[$];
    int n = 0, last = 0, l = lat_of(k);
    pcq.push_back(16'h3000 | 16'($urandom_range(0, 4095)));
    i_instr_rd[k] = 1'b1; i_pc[k] = pcq[0];
    for (int c = 1; c <= 6 * (l + 3) + 10; c++) begin
      @(negedge clk);
      if (o_cmp_i[k]) begin
        $display("txn k=%0d b2b fetch#%0d pc=%h done@%0d instr=%h", k, n, pcq[n], c, o_ins[k]);
        n_checks++; if (o_ins[k] !== model_rd(pcq[n])) begin n_fail++; $display("FAIL b2b_data k=%0d #%0d: got %h expected %h", k, n, o_ins[k], model_rd(pcq[n])); end
        n_checks++;
        if (n == 0) begin
          if (c != 2 + l) begin n_fail++; $display("FAIL b2b_first k=%0d: got %0d expected %0d", k, c, 2 + l); end
        end else if (c - last != l + 3) begin
          n_fail++; $display("FAIL b2b_spacing k=%0d: got %0d expected %0d", k, c - last, l + 3);
        end
        exp_ins[k] = model_rd(pcq[n]);
        last = c; n++;
        if (n == 5) begin i_instr_rd[k] = 1'b0; break; end
        pcq.push_back(16'h3000 | 16'($urandom_range(0, 4095)));
        i_pc[k] = pcq[n];
      end
    end
    i_instr_rd[k] = 1'b0;
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL b2b_count k=%0d: got %0d expected 5", k, n); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int ec, dc; logic [15:0] ea, ew, io, dout; logic we; bit di, dd;
    int l = lat_of(1);
    for (int t = 0; t < 20; t++) begin
      bit is_d = 1'($urandom);
      bit rd   = 1'($urandom);
      logic [15:0] a  = 16'h5000 | 16'($urandom_range(0, 15));
      logic [15:0] wd = 16'($urandom);
      bit is_wr = is_d && !rd;
      observe_access(1, is_d, rd, a, wd, 20, ec, ea, we, ew, dc, di, dd, io, dout);
      n_checks++; if (ec !== 1 || ea !== a || we !== is_wr || (is_wr && ew !== wd)) begin
        n_fail++; $display("FAIL rnd_issue t=%0d: got cyc=%0d addr=%h we=%b wd=%h expected 1/%h/%b/%h", t, ec, ea, we, ew, a, is_wr, wd); end
      n_checks++; if (dc !== 2 + l || dd !== is_d || di !== !is_d) begin
        n_fail++; $display("FAIL rnd_done t=%0d: got cyc=%0d d=%b i=%b expected %0d/%b/%b", t, dc, dd, di, 2 + l, is_d, !is_d); end
      if (is_wr) model_mem[a] = wd;
      else if (is_d) exp_din[1] = model_rd(a);
      else exp_ins[1] = model_rd(a);
      n_checks++; if (io !== exp_ins[1] || dout !== exp_din[1]) begin
        n_fail++; $display("FAIL rnd_data t=%0d: got ins=%h din=%h expected %h/%h", t, io, dout, exp_ins[1], exp_din[1]); end
      n_checks++; if (o_cmp_i[1] !== 1'b0 || o_cmp_d[1] !== 1'b0) begin
        n_fail++; $display("FAIL rnd_pulse_width t=%0d: got %b%b expected 00", t, o_cmp_i[1], o_cmp_d[1]); end
    end
  endtask

  task automatic test_reset_mid();
    int ec, dc; logic [15:0] ea, ew, io, dout; logic we; bit di, dd;
    int seen = 0;
    logic [15:0] q = 16'h3400 | 16'($urandom_range(0, 255));
    i_instr_rd[2] = 1'b1; i_pc[2] = 16'h3300;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_instr_rd[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (o_mem_en[k] !== 1'b0 || o_mem_we[k] !== 1'b0 || o_cmp_i[k] !== 1'b0 || o_cmp_d[k] !== 1'b0) begin
        n_fail++; $display("FAIL midrst_ctl k=%0d: got en=%b we=%b ci=%b cd=%b expected 0000", k, o_mem_en[k], o_mem_we[k], o_cmp_i[k], o_cmp_d[k]); end
      n_checks++; if (o_mem_addr[k] !== 16'h0 || o_mem_wd[k] !== 16'h0 || o_ins[k] !== 16'h0 || o_din[k] !== 16'h0) begin
        n_fail++; $display("FAIL midrst_data k=%0d: got addr=%h wd=%h ins=%h din=%h expected all 0", k, o_mem_addr[k], o_mem_wd[k], o_ins[k], o_din[k]); end
      exp_ins[k] = '0; exp_din[k] = '0;
    end
    for (int c = 7; c <= 2 + lat_of(2) + 2; c++) begin
      @(negedge clk);
      if (o_cmp_i[2] || o_cmp_d[2]) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", seen); end
    observe_access(2, 1'b0, 1'b1, q, 16'h0, 30, ec, ea, we, ew, dc, di, dd, io, dout);
    n_checks++; if (dc !== 2 + lat_of(2) || di !== 1'b1 || io !== model_rd(q)) begin
      n_fail++; $display("FAIL midrst_fresh: got cyc=%0d i=%b ins=%h expected %0d/1/%h", dc, di, io, 2 + lat_of(2), model_rd(q)); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem_arr[a] = 16'(a) ^ 16'h5A5A;
    for (int k = 0; k < 3; k++) begin
      i_instr_rd[k] = 1'b0; i_pc[k] = '0; i_data_req[k] = 1'b0; i_data_rd[k] = 1'b0;
      i_data_addr[k] = '0; i_data_dout[k] = '0; exp_ins[k] = '0; exp_din[k] = '0;
      for (int j = 0; j < 16; j++) rd_pipe[k][j] = '0;
    end
    test_reset();
    test_single_fetch();
    test_data_write();
    test_contention();
    test_starvation();
    test_back_to_back(0);
    test_back_to_back(2);
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Single-port memory arbiter and access sequencer for the LC3 core. Sits between the core's fetch port (`pc`, `instrmem_rd`, `Instr_dout`, `complete_instr`) and its data port (`Data_addr`, `Data_rd`, `Data_dout`, `Data_din`, `complete_data`) and one shared fixed-latency synchronous memory. Grants one access at a time, sequences issue, wait and capture, and returns one-cycle completion pulses to the core.

## Interface
- `LAT`, 1: memory read/write latency in cycles, legal range 1..15.
- `AW`, 16: address width.
- `DW`, 16: data width.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instrmem_rd`  in  1  fetch request (level).
- `pc`  in  AW  fetch address.
- `Instr_dout`  out  DW  fetched instruction; held until the next fetch capture.
- `complete_instr`  out  1  one-cycle fetch-done pulse.
- `data_req`  in  1  data access request (level).
- `Data_rd`  in  1  1 = read, 0 = write; qualified by `data_req`.
- `Data_addr`  in  AW  data address.
- `Data_dout`  in  DW  core write data.
- `Data_din`  out  DW  read data to core; held until the next data-read capture.
- `complete_data`  out  1  one-cycle data-done pulse, for both reads and writes.
- `mem_en`  out  1  memory strobe, one cycle per access.
- `mem_we`  out  1  write enable; valid with `mem_en`.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  valid exactly `LAT` cycles after the `mem_en` cycle.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE:** if any request is high, pick a winner, register its address, write data, `mem_we` and owner, then go to ISSUE. If no request is high, stay in IDLE.
- **ISSUE:** `mem_en`=1 for exactly one cycle. Load the 4-bit counter with `LAT`. Go to WAIT.
- **WAIT:** decrement the counter each cycle.
  - When the counter reaches 1 and the access is a read, capture `mem_rdata` into `Instr_dout` or `Data_din` according to the owner.
  - On that same cycle, go to DONE.
- **DONE:** pulse the owner's `complete_*`. Requests are ignored in this cycle. Go to IDLE.
- Arbitration: data beats fetch, because the core's memory stage stalls the pipeline.
- Writes: `mem_we`=1 and `mem_wdata`=`Data_dout`. `complete_data` still pulses. `Data_din` is unchanged.
- Fetch is always a read: `mem_we`=0.
- Request inputs are sampled only in IDLE. Changes to address or data after the grant are ignored.
- A requester must hold its request until its completion. It may drop the request in the completion cycle. Holding it past completion causes a new access.

## Timing
- Reset values: state IDLE; `mem_en`, `mem_we`, `complete_instr`, `complete_data` = 0; `mem_addr`, `mem_wdata`, `Instr_dout`, `Data_din` = 0; counter 0.
- All outputs are registered.
- Access cycle numbering, with the request seen in IDLE at cycle 0:
  - cycle 1: `mem_en`.
  - cycle 1+`LAT`: `mem_rdata` captured.
  - cycle 2+`LAT`: `complete_*` high and captured data visible.
  - cycle 3+`LAT`: earliest next grant decision; that access's `mem_en` is at cycle 4+`LAT`.
- Occupancy: `LAT`+3 cycles per access.
- Simultaneous fetch and data requests in IDLE: data is granted, and fetch is served in the next IDLE cycle (subject to Configuration).
- Reset asserted mid-access: next cycle returns to IDLE with all reset values. No completion pulse is issued. An already-issued memory write is not retracted.
- `LAT` outside 1..15 is illegal; flag it with a simulation-time `$fatal`.

## Configuration
- `LC3_ARB_FAIRNESS_EN` defined:
  - A one-bit `last_was_data` flag is kept; it resets to 0.
  - If both request and the previous grant was data, fetch wins. This bounds fetch starvation to one data access.
- Not defined: strict data priority. Fetch can starve while `data_req` stays high.

## Test plan
- **Single fetch:** `LAT`=2, `pc`=0x3000, memory word 0x1021, `instrmem_rd` pulsed high until completion.
  - `mem_en` at cycle 1 with `mem_addr`=0x3000 and `mem_we`=0.
  - `complete_instr` at cycle 4 with `Instr_dout`=0x1021.
- **Data write:** `data_req`=1, `Data_rd`=0, `Data_addr`=0x4000, `Data_dout`=0xBEEF.
  - `mem_en`=`mem_we`=1 and `mem_wdata`=0xBEEF at cycle 1.
  - `complete_data` at cycle 2+`LAT`; `Data_din` unchanged.
- **Contention:** fetch and data read requested in the same cycle, `LAT`=1.
  - Data is served first, with `complete_data` at cycle 3.
  - Fetch `mem_en` at cycle 5 and `complete_instr` at cycle 7.
- **Starvation:** `data_req` held high continuously with `instrmem_rd` also high.
  - Without `LC3_ARB_FAIRNESS_EN`: no `complete_instr` for 50 cycles.
  - With the macro: data and fetch completions alternate.
- **Reset mid-access:** assert `reset` during WAIT.
  - Next cycle: all outputs at reset values, and no `complete_*` pulse at the expected cycle.
  - A fresh request after reset completes normally.
- **Latency sweep:** `LAT`=1 and `LAT`=15 with back-to-back fetches.
  - Completion spacing is exactly `LAT`+3 cycles.
